plab2_proc_imem_multi_drop_unit: RTL and testbench

//  Instruction-memory in-flight tracker and response squasher for the pipelined PISA cores.

---
 rtl/plab2_proc_imem_multi_drop_unit.sv | 130 +++++++++++++
 tb/tb_plab2_proc_imem_multi_drop_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/plab2_proc_imem_multi_drop_unit.sv
// Tracks up to p_max_inflight outstanding imem reqs; on squash, drops every resp owed to older reqs.
// Latency: resp path is combinational (0 cycles); req path gating is combinational.
// Backpressure: req_in_rdy drops while the tracker is full; in_rdy follows out_rdy only for live resps.
module plab2_proc_imem_multi_drop_unit #(
    parameter int p_msg_nbits    = 46,
    parameter int p_max_inflight = 4,
    parameter int p_cnt_nbits    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_in_val,
    output logic                   req_in_rdy,
    output logic                   req_out_val,
    input  logic                   req_out_rdy,
    input  logic                   squash,
    input  logic [p_msg_nbits-1:0] in_msg,
    input  logic                   in_val,
    output logic                   in_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_cnt_nbits-1:0] live_count,
    output logic [p_cnt_nbits-1:0] drop_count,
    output logic                   err
);

    typedef logic [p_cnt_nbits-1:0] cnt_t;
    typedef logic [p_cnt_nbits:0]   occ_t;

    localparam occ_t max_occ = occ_t'(p_max_inflight);

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_DROP,
        MODE_SQUASH,
        MODE_PASS
    } mode_t;

    cnt_t  live_q;
    cnt_t  drop_q;
    cnt_t  live_d;
    cnt_t  drop_d;
    logic  err_q;
    mode_t mode;
    logic  full;
    logic  req_fire;
    logic  dfire;
    logic  sfire;
    logic  pfire;
    logic  err_set;

    // Occupancy is judged on the current counts, so a resp retiring this
    // cycle does not open a slot for a req in the same cycle.
    assign full        = (occ_t'(live_q) + occ_t'(drop_q)) == max_occ;
    assign req_out_val = reset & req_in_val & ~full;
    assign req_in_rdy  = reset & req_out_rdy & ~full;
    assign req_fire    = req_out_val & req_out_rdy;

    assign out_msg    = in_msg;
    assign live_count = live_q;
    assign drop_count = drop_q;
    assign err        = err_q;

    // To-drop resps are always older than live ones, so they are consumed first.
    always_comb begin
        mode = MODE_IDLE;
        if (drop_q != '0) begin
            mode = MODE_DROP;
        end else if (live_q != '0) begin
            mode = squash ? MODE_SQUASH : MODE_PASS;
        end
    end

    always_comb begin
        in_rdy  = 1'b0;
        out_val = 1'b0;
        dfire   = 1'b0;
        sfire   = 1'b0;
        pfire   = 1'b0;
        err_set = 1'b0;
        if (reset) begin
            unique case (mode)
                MODE_DROP: begin
                    in_rdy = 1'b1;
                    dfire  = in_val;
                end
                MODE_SQUASH: begin
                    in_rdy = 1'b1;
                    sfire  = in_val;
                end
                MODE_PASS: begin
                    out_val = in_val;
                    in_rdy  = out_rdy;
                    pfire   = in_val & out_rdy;
                end
                default: begin
                    err_set = in_val;
                end
            endcase
        end
    end

    // A req firing in the squash cycle is the redirected fetch and stays live.
    always_comb begin
        live_d = live_q;
        drop_d = drop_q;
        if (squash) begin
            drop_d = drop_q - cnt_t'(dfire) + (live_q - cnt_t'(sfire));
            live_d = cnt_t'(req_fire);
        end else begin
            live_d = live_q + cnt_t'(req_fire) - cnt_t'(pfire);
            drop_d = drop_q - cnt_t'(dfire);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            live_q <= live_d;
            drop_q <= drop_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_plab2_proc_imem_multi_drop_unit.sv
// Vector-table bench for the imem multi-drop unit with a scoreboard of expected delivered resps.
module tb_plab2_proc_imem_multi_drop_unit;

    localparam int MSG_W = 46;
    localparam int CNT_W = 3;
    localparam int MAX_INFLIGHT = 4;

    logic             clk;
    logic             reset;
    logic             req_in_val;
    logic             req_in_rdy;
    logic             req_out_val;
    logic             req_out_rdy;
    logic             squash;
    logic [MSG_W-1:0] in_msg;
    logic             in_val;
    logic             in_rdy;
    logic [MSG_W-1:0] out_msg;
    logic             out_val;
    logic             out_rdy;
    logic [CNT_W-1:0] live_count;
    logic [CNT_W-1:0] drop_count;
    logic             err;

    int checks = 0;
    int errors = 0;
    logic [MSG_W-1:0] exp_q[$];

    plab2_proc_imem_multi_drop_unit #(
        .p_msg_nbits   (MSG_W),
        .p_max_inflight(MAX_INFLIGHT),
        .p_cnt_nbits   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_in_val (req_in_val),
        .req_in_rdy (req_in_rdy),
        .req_out_val(req_out_val),
        .req_out_rdy(req_out_rdy),
        .squash     (squash),
        .in_msg     (in_msg),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .out_msg    (out_msg),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .live_count (live_count),
        .drop_count (drop_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             riv;
        logic             ror;
        logic             sq;
        logic             iv;
        logic [MSG_W-1:0] msg;
        logic             ordy;
        logic             e_ov;
        logic             e_ir;
        logic             e_rov;
        logic             e_rir;
        logic [CNT_W-1:0] e_l;
        logic [CNT_W-1:0] e_d;
        logic             e_err;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic riv, input logic ror,
                                input logic sq, input logic iv, input int msg, input logic ordy,
                                input logic ov, input logic ir, input logic rov, input logic rir,
                                input int l, input int d, input logic e);
        vec_t v;
        v.rst_n = rst_n; v.riv = riv; v.ror = ror; v.sq = sq; v.iv = iv;
        v.msg   = MSG_W'(msg);
        v.ordy  = ordy;
        v.e_ov  = ov; v.e_ir = ir; v.e_rov = rov; v.e_rir = rir;
        v.e_l   = CNT_W'(l);
        v.e_d   = CNT_W'(d);
        v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at negedge; comb outputs are checked 1ns later, state 1ns after posedge.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        reset       = v.rst_n;
        req_in_val  = v.riv;
        req_out_rdy = v.ror;
        squash      = v.sq;
        in_val      = v.iv;
        in_msg      = v.msg;
        out_rdy     = v.ordy;
        #1;
        chk({tag, " out_val"}, 64'(out_val), 64'(v.e_ov));
        chk({tag, " in_rdy"}, 64'(in_rdy), 64'(v.e_ir));
        chk({tag, " req_out_val"}, 64'(req_out_val), 64'(v.e_rov));
        chk({tag, " req_in_rdy"}, 64'(req_in_rdy), 64'(v.e_rir));
        if (v.e_ov && v.ordy) exp_q.push_back(v.msg);
        if (out_val === 1'b1 && out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s resp: got unexpected msg %0h, expected none", tag, out_msg);
            end else begin
                chk({tag, " out_msg"}, 64'(out_msg), 64'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " live_count"}, 64'(live_count), 64'(v.e_l));
        chk({tag, " drop_count"}, 64'(drop_count), 64'(v.e_d));
        chk({tag, " err"}, 64'(err), 64'(v.e_err));
    endtask

    // Occupancy must never exceed the limit; an underflow would wrap and trip this too.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (int'(live_count) + int'(drop_count) > MAX_INFLIGHT) begin
                errors++;
                $display("FAIL occupancy: got L=%0d D=%0d, required L+D <= %0d",
                         live_count, drop_count, MAX_INFLIGHT);
            end
        end
    end

    vec_t tbl[$];

    initial begin
        reset = 1'b0; req_in_val = 1'b0; req_out_rdy = 1'b0; squash = 1'b0;
        in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;

        //            rst riv ror sq iv msg  ordy  ov ir rov rir  L  D  err
        // reset held with in_val and a pending req
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 1, 0, 1, 'h5, 1,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 'h0, 0,  0, 0, 0, 0,  0, 0, 0));
        // fill: four reqs fire, fifth blocked
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  2, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  3, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  4, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 0, 0,  4, 0, 0));
        // drain to L=2
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h1, 1,  1, 1, 0, 0,  3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h2, 1,  1, 1, 0, 0,  2, 0, 0));
        // pass with stall
        tbl.push_back(mk(1, 0, 0, 0, 1, 'hA, 0,  1, 0, 0, 0,  2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'hA, 0,  1, 0, 0, 0,  2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'hA, 1,  1, 1, 0, 0,  1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'hB, 1,  1, 1, 0, 0,  0, 0, 0));
        // squash with a redirected req at L=3
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  2, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  3, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 'h0, 0,  0, 1, 1, 1,  1, 3, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h10, 1, 0, 1, 0, 0,  1, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h11, 1, 0, 1, 0, 0,  1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h12, 1, 0, 1, 0, 0,  1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h13, 1, 1, 1, 0, 0,  0, 0, 0));
        // squash coinciding with a resp, no req
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 'h20, 1, 0, 1, 0, 0,  0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h21, 1, 0, 1, 0, 0,  0, 0, 0));
        // stray resp sets sticky err
        tbl.push_back(mk(1, 0, 0, 0, 1, 'h30, 1, 0, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 'h0, 0,  0, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 'h0, 0,  0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 'h0, 0,  0, 0, 0, 0,  0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Corner: simultaneous req and resp at and near full, then nested squashes.
        for (int i = 0; i < 4; i++)
            apply(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  i + 1, 0, 0), 100 + i);
        apply(mk(1, 1, 1, 0, 1, 'h40, 1, 1, 1, 0, 0,  3, 0, 0), 110);
        apply(mk(1, 1, 1, 0, 1, 'h41, 1, 1, 1, 1, 1,  3, 0, 0), 111);
        apply(mk(1, 1, 1, 1, 1, 'h42, 0, 0, 1, 1, 1,  1, 2, 0), 112);
        apply(mk(1, 0, 0, 1, 1, 'h43, 1, 0, 1, 0, 0,  0, 2, 0), 113);
        apply(mk(1, 0, 0, 0, 1, 'h44, 1, 0, 1, 0, 0,  0, 1, 0), 114);
        apply(mk(1, 0, 0, 0, 1, 'h45, 1, 0, 1, 0, 0,  0, 0, 0), 115);

        // Corner: reset mid-flight, then a resp for the pre-reset req flags err.
        apply(mk(1, 1, 1, 0, 0, 'h0, 0,  0, 0, 1, 1,  1, 0, 0), 120);
        apply(mk(0, 1, 1, 0, 1, 'h50, 1, 0, 0, 0, 0,  0, 0, 0), 121);
        apply(mk(1, 0, 0, 0, 0, 'h0, 0,  0, 0, 0, 0,  0, 0, 0), 122);
        apply(mk(1, 0, 0, 0, 1, 'h50, 1, 0, 0, 0, 0,  0, 0, 1), 123);
        apply(mk(0, 0, 0, 0, 0, 'h0, 0,  0, 0, 0, 0,  0, 0, 0), 124);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
